// File: rtl/johnson_decoder.sv
// Decodes a sampled Johnson count to a binary index, flags illegal words and broken steps,
// counts errors (saturating) and reports lock after LOCK_CNT consecutive good steps. One-cycle latency.
module johnson_decoder #(
   parameter int N        = 4,
   parameter int LOCK_CNT = 4,
   localparam int IW      = $clog2(2 * N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  code_in,
   input  logic          code_valid,
   input  logic          clr_err,
   output logic [IW-1:0] index,
   output logic          index_valid,
   output logic          illegal,
   output logic          seq_err,
   output logic          locked,
   output logic [7:0]    err_count
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [N-1:0]  ONE_N   = N'(1);
   localparam logic [IW-1:0] ONE_I   = IW'(1);
   localparam logic [IW-1:0] LAST    = IW'(2 * N - 1);
   localparam logic [IW-1:0] HALF    = IW'(N);
   localparam logic [7:0]    LOCK_TH = 8'(LOCK_CNT);

   state_t        fsm;
   logic [IW-1:0] ref_idx;
   logic          have_ref;
   logic [7:0]    run;

   logic [N-1:0]  lo_word;
   logic [IW-1:0] ones;
   logic [IW-1:0] dec_idx;
   logic [IW-1:0] succ;
   logic          legal;
   logic          good;
   logic          err_event;
   logic [7:0]    run_inc;

   // Folding the upper half onto the lower half makes every legal word a run of ones from bit 0.
   always_comb begin
      lo_word = code_in[N-1] ? ~code_in : code_in;
      legal   = ((lo_word & (lo_word + ONE_N)) == '0);
      ones    = '0;
      for (int i = 0; i < N; i++) begin
         ones = ones + IW'(lo_word[i]);
      end
      dec_idx   = code_in[N-1] ? (HALF + ones) : ones;
      succ      = (ref_idx == LAST) ? '0 : (ref_idx + ONE_I);
      good      = have_ref && (dec_idx == succ);
      err_event = code_valid && (!legal || (have_ref && !good));
      run_inc   = (run == 8'hFF) ? run : (run + 8'd1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm         <= UNLOCKED;
         ref_idx     <= '0;
         have_ref    <= 1'b0;
         run         <= 8'd0;
         index       <= '0;
         index_valid <= 1'b0;
         illegal     <= 1'b0;
         seq_err     <= 1'b0;
         locked      <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         index_valid <= 1'b0;
         illegal     <= 1'b0;
         seq_err     <= 1'b0;
         if (code_valid) begin
            if (!legal) begin
               illegal  <= 1'b1;
               have_ref <= 1'b0;
               run      <= 8'd0;
               fsm      <= UNLOCKED;
               locked   <= 1'b0;
            end else begin
               index       <= dec_idx;
               index_valid <= 1'b1;
               ref_idx     <= dec_idx;
               have_ref    <= 1'b1;
               if (!have_ref) begin
                  run <= 8'd0;
               end else if (good) begin
                  run <= run_inc;
                  if (fsm == UNLOCKED && run_inc >= LOCK_TH) begin
                     fsm    <= LOCKED;
                     locked <= 1'b1;
                  end
               end else begin
                  seq_err <= 1'b1;
                  run     <= 8'd0;
                  fsm     <= UNLOCKED;
                  locked  <= 1'b0;
               end
            end
         end
         if (clr_err) begin
            err_count <= 8'd0;
         end else if (err_event && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the 4-bit Johnson counter. The block samples a Johnson-coded count each cycle it is valid and decodes it to a binary index. It flags illegal code words and out-of-sequence steps, keeps a saturating error count, and reports lock once the incoming sequence has stepped correctly for a programmable run length. It sits downstream of any Johnson-counter source, such as a counter `count` bus carried across a module boundary.

## Interface
- `N`, default 4: Johnson register width. Sequence length is 2N states. N ≥ 2.
- `LOCK_CNT`, default 4: number of consecutive in-sequence steps required to assert lock. Range 1..255.
- `IW`, default $clog2(2N) (3 for N=4): index width, derived, not overridden.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `code_in`, input, N: Johnson code word. Bit 0 is the stage fed by the inverted MSB.
- `code_valid`, input, 1: `code_in` is sampled on this cycle.
- `clr_err`, input, 1: synchronous clear of `err_count`.
- `index`, output, IW: last legal decoded index, 0..2N-1.
- `index_valid`, output, 1: one-cycle pulse. `index` was updated from a legal sample.
- `illegal`, output, 1: one-cycle pulse. The sampled word was not a Johnson code.
- `seq_err`, output, 1: one-cycle pulse. The word was legal but was not the successor of the reference.
- `locked`, output, 1: level. The sequence is tracked.
- `err_count`, output, 8: saturating count of `illegal` plus `seq_err` events.

## Operation
- **Legal words.** There are 2N legal words.
  - MSB = 0: the word must be 2^k−1, for k = 0..N−1.
  - MSB = 1: the word must be the ones-complement of 2^k−1 within N bits, for k = 0..N−1.
  - For N=4 the sequence is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, giving index 0..7.
- **Decode.** Let p = popcount(`code_in`).
  - If MSB = 0, index = p.
  - If MSB = 1, index = 2N − p.
- **Internal state.**
  - `ref_idx`: reference index.
  - `have_ref`: a reference is held.
  - `run`: 8-bit count of consecutive good steps.
  - `fsm`: one of UNLOCKED or LOCKED.
- **Samples with `code_valid` = 0.** No state change and no pulses. Gaps do not break the sequence.
- **Illegal word.**
  - Pulse `illegal`.
  - `have_ref` ← 0, `run` ← 0, `fsm` ← UNLOCKED.
  - `index` holds its value. No `index_valid` pulse.
- **Legal word with `have_ref` = 0.**
  - Load `ref_idx`, set `have_ref`, `run` ← 0.
  - Pulse `index_valid`. No `seq_err`.
- **Legal word with `have_ref` = 1 and index = (`ref_idx`+1) mod 2N.** This is a good step.
  - `run` ← min(`run`+1, 255).
  - Load `ref_idx` and pulse `index_valid`.
  - In UNLOCKED, when the new `run` equals or exceeds `LOCK_CNT`, move to LOCKED.
- **Legal word with `have_ref` = 1, any other index.** This includes a repeated index and a backward step.
  - Pulse `seq_err` and `index_valid`.
  - Load `ref_idx` with the new index, `run` ← 0, `fsm` ← UNLOCKED.
- **Wrap-around.** Index 2N−1 followed by index 0 is a good step.
- **`err_count`.**
  - Increments by 1 on each `illegal` or `seq_err` event and saturates at 255.
  - When `clr_err` and an error occur in the same cycle, clear wins and the count is 0.
- **FSM summary.**
  - UNLOCKED → LOCKED when a good step brings `run` to `LOCK_CNT` or above.
  - LOCKED → UNLOCKED on `illegal` or `seq_err`.
  - In all other cases the state holds.

## Timing
- All outputs are registered.
- Latency: a sample taken at edge t produces its outputs and pulses after edge t+1. That is one cycle of latency.
- `locked` rises in the same cycle as the `index_valid` of the step that completes the run.
- `locked` falls in the same cycle as the offending `illegal` or `seq_err` pulse.
- Back-to-back `code_valid` is supported every cycle with no throughput loss.
- Reset values: `index` = 0, `index_valid` = 0, `illegal` = 0, `seq_err` = 0, `locked` = 0, `err_count` = 0.
- Reset values of internal state: `have_ref` = 0, `run` = 0, `fsm` = UNLOCKED.
- Reset asserted mid-sequence takes effect immediately, asynchronously. The first legal sample after release only establishes the reference.

## Test plan
1. **Free-running source.** Drive the N=4 sequence starting at 0000 with `code_valid` = 1 every cycle.
   - `index` must read 0, 1, 2, …, 7, 0 with `index_valid` high continuously.
   - `locked` must rise with index 4, the 4th good step.
   - `err_count` must stay 0.
2. **Illegal word.** While locked, inject 0101.
   - `illegal` pulses once, `locked` drops, `index` holds, `err_count` = 1.
   - Resume at 0011: no `seq_err`, re-lock after 4 further good steps.
3. **Skip.** While locked, go from 0111 directly to 1110 (index 3 → 5).
   - `seq_err` pulses, `index` = 5, `locked` drops, `err_count` increments.
4. **Gaps and wrap.** Send 1000, idle 3 cycles with `code_valid` = 0, then send 0000.
   - This counts as a good step: no errors, `run` increments.
5. **Saturation and clear.** Inject 300 illegal words.
   - `err_count` = 255.
   - Assert `clr_err` together with another illegal word: `err_count` = 0 and `illegal` still pulses.
6. **Reset mid-operation.** Pulse `rst` while locked at index 6.
   - All outputs go to their reset values immediately.
   - The next sample, 0001, gives `index` = 1 with no `seq_err` and `locked` = 0.
